// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// Shared scan-segment layout for the gate1 observation/control TDR.
// Bit 0 is the select, bit 1 the capture mode, and the data field starts at bit 2.
package firebird7_in_gate1_tdr_pkg;

  localparam int TDR_SEL_BIT  = 0;
  localparam int TDR_MODE_BIT = 1;
  localparam int TDR_DATA_LSB = 2;

  function automatic int tdr_len(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_obs_ctl_w19.sv
// Leaf IJTAG TDR: drives select/data of the gate1 data mux and captures the mux output
// (or reads back its own update register) for shifting out on a WIDTH+2 bit segment.
module firebird7_in_gate1_tessent_tdr_obs_ctl_w19
  import firebird7_in_gate1_tdr_pkg::*;
#(
  parameter int   WIDTH     = 19,
  parameter logic RESET_SEL = 1'b0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] observed_data,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             capture_mode
);

  localparam int LEN = tdr_len(WIDTH);

  logic [LEN-1:0] sr_q, sr_d;
  logic [LEN-1:0] ur_q, ur_d;

  // Capture takes priority over shift when both enables are high.
  always_comb begin
    sr_d = sr_q;
    if (ijtag_sel) begin
      if (ijtag_ce) begin
        sr_d[TDR_SEL_BIT]            = ur_q[TDR_SEL_BIT];
        sr_d[TDR_MODE_BIT]           = ur_q[TDR_MODE_BIT];
        sr_d[LEN-1:TDR_DATA_LSB]     = ur_q[TDR_MODE_BIT] ? ur_q[LEN-1:TDR_DATA_LSB]
                                                          : observed_data;
      end else if (ijtag_se) begin
        sr_d = {ijtag_si, sr_q[LEN-1:1]};
      end
    end
  end

  // Update copies the pre-edge shift register, so it may overlap a shift or capture.
  always_comb begin
    ur_d = ur_q;
    if (ijtag_sel && ijtag_ue) begin
      ur_d = sr_q;
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      ur_q              <= '0;
      ur_q[TDR_SEL_BIT] <= RESET_SEL;
    end else begin
      ur_q <= ur_d;
    end
  end

  assign ijtag_so       = sr_q[TDR_SEL_BIT];
  assign ijtag_select   = ur_q[TDR_SEL_BIT];
  assign capture_mode   = ur_q[TDR_MODE_BIT];
  assign ijtag_data_out = ur_q[LEN-1:TDR_DATA_LSB];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_obs_ctl_w19.sv
// Self-checking bench for the gate1 observation/control TDR.
// Reference model keeps the scan segment as a bit queue (front = scan-out end).
module tb_firebird7_in_gate1_tessent_tdr_obs_ctl_w19;

  localparam int W = 19;
  localparam int L = W + 2;

  logic         ijtag_tck = 1'b0;
  logic         ijtag_reset;
  logic         ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic         ijtag_so;
  logic [W-1:0] observed_data;
  logic         ijtag_select;
  logic [W-1:0] ijtag_data_out;
  logic         capture_mode;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit           mq[$];
  bit           m_sel, m_mode;
  logic [W-1:0] m_data;
  logic [W-1:0] exp_q[$];

  firebird7_in_gate1_tessent_tdr_obs_ctl_w19 #(.WIDTH(W), .RESET_SEL(1'b0)) dut (
    .ijtag_tck      (ijtag_tck),
    .ijtag_reset    (ijtag_reset),
    .ijtag_sel      (ijtag_sel),
    .ijtag_ce       (ijtag_ce),
    .ijtag_se       (ijtag_se),
    .ijtag_ue       (ijtag_ue),
    .ijtag_si       (ijtag_si),
    .ijtag_so       (ijtag_so),
    .observed_data  (observed_data),
    .ijtag_select   (ijtag_select),
    .ijtag_data_out (ijtag_data_out),
    .capture_mode   (capture_mode)
  );

  // clock
  always #5 ijtag_tck = ~ijtag_tck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < L; i++) mq.push_back(1'b0);
    m_sel  = 1'b0;
    m_mode = 1'b0;
    m_data = '0;
  endfunction

  function automatic void model_edge(input bit sel, input bit ce, input bit se,
                                     input bit ue, input bit si, input logic [W-1:0] obs);
    bit           nq[$];
    logic [W-1:0] cap;
    if (!sel) return;
    nq = mq;
    if (ce) begin
      cap = m_mode ? m_data : obs;
      nq.delete();
      nq.push_back(m_sel);
      nq.push_back(m_mode);
      for (int i = 0; i < W; i++) nq.push_back(cap[i]);
    end else if (se) begin
      void'(nq.pop_front());
      nq.push_back(si);
    end
    if (ue) begin
      m_sel  = mq[0];
      m_mode = mq[1];
      for (int i = 0; i < W; i++) m_data[i] = mq[i+2];
    end
    mq = nq;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".so"},     {31'd0, ijtag_so},     {31'd0, mq[0]});
    check({tag, ".select"}, {31'd0, ijtag_select}, {31'd0, m_sel});
    check({tag, ".mode"},   {31'd0, capture_mode}, {31'd0, m_mode});
    check({tag, ".data"},   {13'd0, ijtag_data_out}, {13'd0, m_data});
  endtask

  // driver: inputs change 1ns after a posedge, outputs sampled 1ns after the next one
  task automatic step(input string tag, input bit sel, input bit ce, input bit se,
                      input bit ue, input bit si);
    ijtag_sel = sel; ijtag_ce = ce; ijtag_se = se; ijtag_ue = ue; ijtag_si = si;
    @(posedge ijtag_tck);
    model_edge(sel, ce, se, ue, si, observed_data);
    #1;
    check_outputs(tag);
  endtask

  task automatic pulse_reset(input string tag);
    ijtag_reset = 1'b0;
    model_reset();
    #1;
    check({tag, ".select"}, {31'd0, ijtag_select}, 32'd0);
    check({tag, ".mode"},   {31'd0, capture_mode}, 32'd0);
    check({tag, ".data"},   {13'd0, ijtag_data_out}, 32'd0);
    check({tag, ".so"},     {31'd0, ijtag_so},     32'd0);
    #1;
    ijtag_reset = 1'b1;
  endtask

  task automatic shift_vec(input string tag, input logic [L-1:0] v);
    for (int i = 0; i < L; i++) step(tag, 1'b1, 1'b0, 1'b1, 1'b0, v[i]);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rd_sel, rd_mode;
    ijtag_reset = 1'b0;
    ijtag_sel = 0; ijtag_ce = 0; ijtag_se = 0; ijtag_ue = 0; ijtag_si = 0;
    observed_data = '0;
    model_reset();

    // 1. reset
    repeat (3) @(posedge ijtag_tck);
    #1;
    check_outputs("reset_hold");
    ijtag_reset = 1'b1;
    for (int i = 0; i < 10; i++) step("pre_reset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("pre_reset_ue", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_reset("reset_pulse");

    // 2. load
    shift_vec("load", {19'h5A5A5, 1'b0, 1'b1});
    step("load_ue", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("load.select_const", {31'd0, ijtag_select}, 32'd1);
    check("load.data_const",   {13'd0, ijtag_data_out}, {13'd0, 19'h5A5A5});

    // 3. observe: expected stream 1,0 then 19 ones
    observed_data = 19'h7FFFF;
    step("obs_ce", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(1); exp_q.push_back(0);
    for (int i = 0; i < W; i++) exp_q.push_back(1);
    while (exp_q.size() > 0) begin
      check("obs.stream", {31'd0, ijtag_so}, {13'd0, exp_q.pop_front()});
      step("obs_shift", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // 4. readback
    shift_vec("rb_load", {19'h5A5A5, 1'b1, 1'b1});
    step("rb_ue", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    observed_data = '0;
    step("rb_ce", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rd_sel = ijtag_so;
    step("rb_shift", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rd_mode = ijtag_so;
    for (int i = 0; i < W; i++) begin
      step("rb_shift", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      rd[i] = ijtag_so;
    end
    check("rb.sel",  {31'd0, rd_sel},  32'd1);
    check("rb.mode", {31'd0, rd_mode}, 32'd1);
    check("rb.data", {13'd0, rd},      {13'd0, 19'h5A5A5});

    // 5. deselect
    for (int i = 0; i < 30; i++) begin
      observed_data = W'($urandom);
      step("desel", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    check("desel.data_const", {13'd0, ijtag_data_out}, {13'd0, 19'h5A5A5});

    // 6. collisions
    observed_data = 19'h12345;
    shift_vec("col_load", {19'h00F0F, 1'b0, 1'b1});
    step("col_ue", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("col_cese", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("col.cese_so", {31'd0, ijtag_so}, 32'd1);
    shift_vec("col_sr1", 21'h1);
    step("col_uese", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("col.ue_sel",  {31'd0, ijtag_select}, 32'd1);
    check("col.ue_mode", {31'd0, capture_mode}, 32'd0);
    check("col.ue_data", {13'd0, ijtag_data_out}, 32'd0);
    check("col.ue_so",   {31'd0, ijtag_so}, 32'd0);

    // randomized traffic with occasional async reset
    for (int i = 0; i < 600; i++) begin
      observed_data = W'($urandom);
      if ($urandom_range(0, 59) == 0) pulse_reset("rand_reset");
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
